mem_access_unit: RTL and testbench

//  MEM-stage load/store unit fed by the EX/MEM pipeline register (ALUResultM, WriteDataM, MemReadM, MemWriteM).

---
 rtl/mem_access_unit.sv | 217 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one data-memory bus transaction per load/store,
// formats load data, stalls the pipeline while busy and reports access faults.
module mem_access_unit #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  Funct3M,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemFaultM,
  output logic [1:0]  FaultCauseM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state;
  state_t               next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 lat_load;
  logic [2:0]           lat_f3;
  logic [1:0]           lat_off;
  logic                 tmo_flag;

  logic                 access;
  logic                 is_load;
  logic                 legal_f3;
  logic                 misaligned;
  logic                 issue;
  logic                 timeout_hit;
  logic [3:0]           req_be;
  logic [31:0]          req_wdata;

  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      2'd3:    b = data[31:24];
      default: b = data[7:0];
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = data;
    endcase
    return r;
  endfunction

  // Access decode: legality, alignment and store lane placement.
  always_comb begin
    access     = MemReadM | MemWriteM;
    is_load    = MemReadM;
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    req_be     = 4'b1111;
    req_wdata  = WriteDataM;
    case (Funct3M)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = is_load;
      default:                legal_f3 = 1'b0;
    endcase
    case (Funct3M[1:0])
      2'b01:   misaligned = ALUResultM[0];
      2'b10:   misaligned = |ALUResultM[1:0];
      default: misaligned = 1'b0;
    endcase
    if (is_load) begin
      req_be    = 4'b1111;
      req_wdata = WriteDataM;
    end else begin
      case (Funct3M[1:0])
        2'b00: begin
          req_be    = 4'b0001 << ALUResultM[1:0];
          req_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          req_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = WriteDataM;
        end
      endcase
    end
  end

  // Next-state logic plus combinational stall and fault outputs.
  always_comb begin
    next_state  = state;
    StallM      = 1'b0;
    MemFaultM   = 1'b0;
    FaultCauseM = 2'b00;
    issue       = 1'b0;
    timeout_hit = 1'b0;
    if (reset) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!access) begin
            next_state = IDLE;
          end else if (!legal_f3) begin
            MemFaultM   = 1'b1;
            FaultCauseM = 2'b10;
          end else if (misaligned) begin
            MemFaultM   = 1'b1;
            FaultCauseM = 2'b01;
          end else begin
            StallM     = 1'b1;
            issue      = 1'b1;
            next_state = BUSY;
          end
        end
        BUSY: begin
          StallM = 1'b1;
          if (dmem_ack) begin
            next_state = DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_hit = 1'b1;
            next_state  = DONE;
          end else begin
            next_state = BUSY;
          end
        end
        DONE: begin
          next_state = IDLE;
          if (tmo_flag) begin
            MemFaultM   = 1'b1;
            FaultCauseM = 2'b11;
          end else begin
            MemFaultM   = 1'b0;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bus request, latched transaction attributes, timeout counter and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_wdata <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      ReadDataM  <= 32'h0000_0000;
      cnt        <= '0;
      lat_load   <= 1'b0;
      lat_f3     <= 3'b000;
      lat_off    <= 2'b00;
      tmo_flag   <= 1'b0;
    end else begin
      tmo_flag <= timeout_hit;
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ~is_load;
        dmem_addr  <= {ALUResultM[31:2], 2'b00};
        dmem_wdata <= req_wdata;
        dmem_be    <= req_be;
        lat_load   <= is_load;
        lat_f3     <= Funct3M;
        lat_off    <= ALUResultM[1:0];
        cnt        <= '0;
      end else if (state == BUSY) begin
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          if (lat_load) begin
            ReadDataM <= format_load(lat_f3, lat_off, dmem_rdata);
          end
        end else if (timeout_hit) begin
          dmem_req <= 1'b0;
        end else begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM, dmem_addr, dmem_wdata, dmem_rdata;
  logic [2:0]  Funct3M;
  logic        MemReadM, MemWriteM, StallM, MemFaultM, dmem_req, dmem_we, dmem_ack;
  logic [1:0]  FaultCauseM;
  logic [3:0]  dmem_be;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_read;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .Funct3M(Funct3M), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ReadDataM(ReadDataM),
    .StallM(StallM), .MemFaultM(MemFaultM), .FaultCauseM(FaultCauseM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One pipeline instruction; waits >= TMO means the bus never acknowledges.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] bus_data);
    logic        legal, misal, tmo;
    int          off, size, busy_n, stalls;
    logic [3:0]  ebe;
    logic [31:0] ewd, eval, bval, hval;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    off = int'(addr[1:0]);
    if (!(rd | wr)) begin
      @(negedge clk);
      check("idle_stall", 32'(StallM), 32'd0);
      check("idle_fault", 32'(MemFaultM), 32'd0);
      check("idle_req", 32'(dmem_req), 32'd0);
      check("idle_rdata", ReadDataM, exp_read);
      return;
    end
    if (rd) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    size  = 1 << int'(f3[1:0]);
    misal = legal && ((off % size) != 0);
    if (!legal || misal) begin
      @(negedge clk);
      check("flt_pulse", 32'(MemFaultM), 32'd1);
      check("flt_cause", 32'(FaultCauseM), legal ? 32'd1 : 32'd2);
      check("flt_stall", 32'(StallM), 32'd0);
      check("flt_req", 32'(dmem_req), 32'd0);
      check("flt_rdata", ReadDataM, exp_read);
      return;
    end
    bval = (bus_data >> (8 * off)) & 32'hFF;
    hval = (bus_data >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    eval = (bval >= 32'd128) ? bval + 32'hFFFF_FF00 : bval;
      3'd1:    eval = (hval >= 32'd32768) ? hval + 32'hFFFF_0000 : hval;
      3'd4:    eval = bval;
      3'd5:    eval = hval;
      default: eval = bus_data;
    endcase
    if (rd) begin
      ebe = 4'hF; ewd = wd;
    end else begin
      case (f3)
        3'd0:    begin ebe = 4'(1 << off); ewd = (wd & 32'hFF) * 32'h0101_0101; end
        3'd1:    begin ebe = (off >= 2) ? 4'hC : 4'h3; ewd = (wd & 32'hFFFF) * 32'h0001_0001; end
        default: begin ebe = 4'hF; ewd = wd; end
      endcase
    end
    tmo    = (waits >= TMO);
    busy_n = tmo ? TMO : waits + 1;
    stalls = 0;
    @(negedge clk);
    stalls += int'(StallM);
    check("issue_req", 32'(dmem_req), 32'd0);
    check("issue_fault", 32'(MemFaultM), 32'd0);
    for (int c = 0; c < busy_n; c++) begin
      @(posedge clk); #1;
      dmem_ack   = (!tmo && c == waits);
      dmem_rdata = (!tmo && c == waits) ? bus_data : $urandom;
      @(negedge clk);
      stalls += int'(StallM);
      check("busy_req", 32'(dmem_req), 32'd1);
      check("busy_we", 32'(dmem_we), rd ? 32'd0 : 32'd1);
      check("busy_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("busy_be", 32'(dmem_be), 32'(ebe));
      check("busy_fault", 32'(MemFaultM), 32'd0);
      if (!rd) check("busy_wdata", dmem_wdata, ewd);
    end
    @(posedge clk); #1;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    if (rd && !tmo) exp_read = eval;
    @(negedge clk);
    check("done_stall", 32'(StallM), 32'd0);
    check("stall_cycles", 32'(stalls), 32'(busy_n + 1));
    check("done_req", 32'(dmem_req), 32'd0);
    check("done_fault", 32'(MemFaultM), tmo ? 32'd1 : 32'd0);
    check("done_cause", 32'(FaultCauseM), tmo ? 32'd3 : 32'd0);
    check("done_rdata", ReadDataM, exp_read);
  endtask

  initial begin
    reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
    ALUResultM = 32'd0; WriteDataM = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
    exp_read = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_fault", 32'(MemFaultM), 32'd0);
    check("rst_cause", 32'(FaultCauseM), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 32'hDEAD_BEEF);
    check("lw_value", ReadDataM, 32'hDEAD_BEEF);
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 32'h8011_2233);
    check("lb_value", ReadDataM, 32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h8011_2233);
    check("lbu_value", ReadDataM, 32'h0000_0080);
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 3, 32'h5555_5555);
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 32'd0);
    run_access(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 0, 32'd0);
    run_access(1'b1, 1'b1, 3'b101, 32'h2, 32'hFFFF_FFFF, 2, 32'h9ABC_0000);
    run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 99, 32'h1111_1111);
    check("tmo_keep", ReadDataM, 32'h0000_9ABC);

    // Reset during the second BUSY cycle with an ack pending.
    @(posedge clk); #1;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h300; dmem_ack = 1'b0;
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    check("rb_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; dmem_ack = 1'b0; MemReadM = 1'b0; exp_read = 32'd0;
    @(negedge clk);
    check("rb_req0", 32'(dmem_req), 32'd0);
    check("rb_stall", 32'(StallM), 32'd0);
    check("rb_fault", 32'(MemFaultM), 32'd0);
    check("rb_rdata", ReadDataM, 32'd0);
    @(posedge clk); #1 dmem_ack = 1'b1;
    @(negedge clk);
    check("rb_req_hold", 32'(dmem_req), 32'd0);
    check("rb_fault_hold", 32'(MemFaultM), 32'd0);
    check("rb_rdata_hold", ReadDataM, 32'd0);

    for (int i = 0; i < 200; i++) begin
      run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, int'($urandom_range(0, 5)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
